// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, ALU operation codes, base opcodes
// and the decoded-instruction payload handed from decode to execute.
package rv32i_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ALU_CODE_W = 6;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_W   = 7;

    typedef logic [ALU_CODE_W-1:0] alu_code_t;
    typedef logic [OPCODE_W-1:0]   opcode_t;

    localparam alu_code_t ALU_RAM  = 6'b000000;
    localparam alu_code_t ALU_ADD  = 6'b000001;
    localparam alu_code_t ALU_SLT  = 6'b000010;
    localparam alu_code_t ALU_SLTU = 6'b000011;
    localparam alu_code_t ALU_SLL  = 6'b000100;
    localparam alu_code_t ALU_SRL  = 6'b000101;
    localparam alu_code_t ALU_SRA  = 6'b000110;
    localparam alu_code_t ALU_XOR  = 6'b000111;
    localparam alu_code_t ALU_OR   = 6'b001000;
    localparam alu_code_t ALU_AND  = 6'b001001;
    localparam alu_code_t ALU_SUB  = 6'b001010;
    localparam alu_code_t ALU_NOP  = 6'b111111;

    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;

    localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_code_t               alu_code;
        logic [DATA_WIDTH-1:0]   oprand_a;
        logic [DATA_WIDTH-1:0]   oprand_b;
        logic [DATA_WIDTH-1:0]   store_data;
        logic [REG_ADDR_W-1:0]   rd_addr;
        logic                    rd_we;
        logic                    mem_rd;
        logic                    mem_wr;
        logic                    illegal;
    } decode_t;

    // Bubble payload: no operation, no side effects.
    localparam decode_t DECODE_IDLE = '{alu_code: ALU_NOP, default: '0};

    // ALU code for funct3 with the base (0000000) funct7 encoding.
    function automatic alu_code_t base_alu_code(input logic [FUNCT3_W-1:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: instruction word plus operands in, ALU code,
// operand pair, memory/writeback control and illegal flag out.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output decode_t               dec_c
);

    opcode_t                 opcode;
    logic [FUNCT3_W-1:0]     funct3;
    logic [FUNCT7_W-1:0]     funct7;
    logic [REG_ADDR_W-1:0]   rd;
    logic [DATA_WIDTH-1:0]   imm_i;
    logic [DATA_WIDTH-1:0]   imm_s;
    logic [DATA_WIDTH-1:0]   imm_u;
    logic [DATA_WIDTH-1:0]   shamt;
    decode_t                 raw;
    logic                    legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = DATA_WIDTH'(instr[24:20]);

    // Field extraction per opcode; legality decided alongside.
    always_comb begin
        raw   = DECODE_IDLE;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                raw.oprand_a = rs1_data;
                raw.oprand_b = rs2_data;
                raw.rd_addr  = rd;
                raw.rd_we    = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal        = 1'b1;
                    raw.alu_code = base_alu_code(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal        = 1'b1;
                    raw.alu_code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal        = 1'b1;
                    raw.alu_code = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                raw.oprand_a = rs1_data;
                raw.oprand_b = imm_i;
                raw.rd_addr  = rd;
                raw.rd_we    = 1'b1;
                raw.alu_code = base_alu_code(funct3);
                case (funct3)
                    3'b001: begin
                        raw.oprand_b = shamt;
                        legal        = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        raw.oprand_b = shamt;
                        if (funct7 == F7_BASE) begin
                            legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            legal        = 1'b1;
                            raw.alu_code = ALU_SRA;
                        end
                    end
                    default: legal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                legal        = 1'b1;
                raw.alu_code = ALU_RAM;
                raw.oprand_a = rs1_data;
                raw.oprand_b = imm_i;
                raw.rd_addr  = rd;
                raw.rd_we    = 1'b1;
                raw.mem_rd   = 1'b1;
            end
            OPC_STORE: begin
                legal          = 1'b1;
                raw.alu_code   = ALU_RAM;
                raw.oprand_a   = rs1_data;
                raw.oprand_b   = imm_s;
                raw.store_data = rs2_data;
                raw.mem_wr     = 1'b1;
            end
            OPC_LUI: begin
                legal        = 1'b1;
                raw.alu_code = ALU_ADD;
                raw.oprand_b = imm_u;
                raw.rd_addr  = rd;
                raw.rd_we    = 1'b1;
            end
            OPC_AUIPC: begin
                legal        = 1'b1;
                raw.alu_code = ALU_ADD;
                raw.oprand_a = pc;
                raw.oprand_b = imm_u;
                raw.rd_addr  = rd;
                raw.rd_we    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings collapse to a side-effect-free bubble; x0 never writes back.
    always_comb begin
        dec_c = raw;
        if (!legal) begin
            dec_c         = DECODE_IDLE;
            dec_c.illegal = 1'b1;
        end else if (raw.rd_addr == '0) begin
            dec_c.rd_we = 1'b0;
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Decode/issue stage: one-deep registered output slot between fetch/regfile
// read and the ALU, with valid/ready handshake, flush and issue counter.
module rv32i_decode_stage
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CODE_W-1:0] alu_code,
    output logic [DATA_WIDTH-1:0] oprand_a,
    output logic [DATA_WIDTH-1:0] oprand_b,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_we,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] issue_count
);

    decode_t dec_c;
    decode_t out_q;
    logic    accept_c;
    logic    xfer_c;

    rv32i_decoder u_decoder (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec_c    (dec_c)
    );

    // Slot can take a new instruction when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready && !flush;
    assign xfer_c   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_q       <= DECODE_IDLE;
            issue_count <= '0;
        end else begin
            if (xfer_c) begin
                issue_count <= issue_count + DATA_WIDTH'(1);
            end
            // Emptied slot keeps stale data but never presents a live ALU op.
            if (flush) begin
                out_valid      <= 1'b0;
                out_q.alu_code <= ALU_NOP;
            end else if (accept_c) begin
                out_valid <= 1'b1;
                out_q     <= dec_c;
            end else if (xfer_c) begin
                out_valid      <= 1'b0;
                out_q.alu_code <= ALU_NOP;
            end
        end
    end

    assign alu_code   = out_q.alu_code;
    assign oprand_a   = out_q.oprand_a;
    assign oprand_b   = out_q.oprand_b;
    assign store_data = out_q.store_data;
    assign rd_addr    = out_q.rd_addr;
    assign rd_we      = out_q.rd_we;
    assign mem_rd     = out_q.mem_rd;
    assign mem_wr     = out_q.mem_wr;
    assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed cases from the instruction list, then
// randomized traffic scored against a queue-based reference model.
module tb_rv32i_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_code;
    logic [31:0] oprand_a;
    logic [31:0] oprand_b;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
    logic [31:0] issue_count;

    int unsigned n_total;
    int unsigned n_bad;

    typedef struct {
        logic [5:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int unsigned exp_cnt;

    rv32i_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_code    (alu_code),
        .oprand_a    (oprand_a),
        .oprand_b    (oprand_b),
        .store_data  (store_data),
        .rd_addr     (rd_addr),
        .rd_we       (rd_we),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .illegal     (illegal),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    // Reference decode computed from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc_v,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        int          op;
        int          f3;
        int          f7;
        bit          ok;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [5:0]  codes [8];
        codes = '{6'd1, 6'd4, 6'd2, 6'd3, 6'd7, 6'd5, 6'd8, 6'd9};
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        imm_i = 32'($signed(ins) >>> 20);
        imm_s = 32'(($signed(ins) >>> 25) <<< 5) | {27'd0, ins[11:7]};
        imm_u = ins & 32'hFFFF_F000;
        ok = 0;
        e.alu = 6'h3F; e.a = 0; e.b = 0; e.sd = 0; e.rd = 0;
        e.we = 0; e.mr = 0; e.mw = 0; e.ill = 0;
        if (op == 'h33) begin
            ok    = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.alu = (f7 == 'h20) ? ((f3 == 0) ? 6'd10 : 6'd6) : codes[f3];
            e.a = r1; e.b = r2; e.we = 1;
        end else if (op == 'h13) begin
            ok    = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 'h20);
            e.alu = (f3 == 5 && f7 == 'h20) ? 6'd6 : codes[f3];
            e.a   = r1;
            e.b   = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : imm_i;
            e.we  = 1;
        end else if (op == 'h03) begin
            ok = 1; e.alu = 0; e.a = r1; e.b = imm_i; e.mr = 1; e.we = 1;
        end else if (op == 'h23) begin
            ok = 1; e.alu = 0; e.a = r1; e.b = imm_s; e.mw = 1; e.sd = r2;
        end else if (op == 'h37) begin
            ok = 1; e.alu = 1; e.a = 0; e.b = imm_u; e.we = 1;
        end else if (op == 'h17) begin
            ok = 1; e.alu = 1; e.a = pc_v; e.b = imm_u; e.we = 1;
        end
        if (!ok) begin
            e.alu = 6'h3F; e.a = 0; e.b = 0; e.sd = 0; e.rd = 0;
            e.we = 0; e.mr = 0; e.mw = 0; e.ill = 1;
        end else begin
            e.rd = (op == 'h23) ? 5'd0 : ins[11:7];
            e.we = e.we && (e.rd != 0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h73};
        w = $urandom;
        w[6:0] = ops[$urandom_range(9, 0)];
        case ($urandom_range(3, 0))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(7, 0) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        n_total = 0; n_bad = 0; exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_code", 32'(alu_code), 32'h3F);
        check("rst_issue_count", issue_count, 32'd0);
        check("rst_oprand_a", oprand_a, 32'd0);
        check("rst_oprand_b", oprand_b, 32'd0);
        check("rst_store_data", store_data, 32'd0);
        check("rst_ctrl", 32'({rd_addr, rd_we, mem_rd, mem_wr, illegal}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        rst = 1'b0; out_ready = 1'b1;
        drive(32'h002081B3, 32'd5, 32'd7); step();
        check("add_alu", 32'(alu_code), 32'h01);
        check("add_a", oprand_a, 32'd5);
        check("add_b", oprand_b, 32'd7);
        check("add_rd", 32'(rd_addr), 32'd3);
        check("add_we", 32'(rd_we), 32'd1);
        check("add_valid", 32'(out_valid), 32'd1);
        drive(32'h402081B3, 32'd5, 32'd7); step();
        check("sub_alu", 32'(alu_code), 32'h0A);
        drive(32'hFFF00293, 32'd0, 32'd0); step();
        check("addi_b", oprand_b, 32'hFFFF_FFFF);
        check("addi_rd", 32'(rd_addr), 32'd5);
        drive(32'h4030D393, 32'h80, 32'd0); step();
        check("srai_alu", 32'(alu_code), 32'h06);
        check("srai_b", oprand_b, 32'd3);
        drive(32'h123450B7, 32'd9, 32'd9); step();
        check("lui_a", oprand_a, 32'd0);
        check("lui_b", oprand_b, 32'h1234_5000);
        drive(32'h00812303, 32'd100, 32'd0); step();
        check("lw_alu", 32'(alu_code), 32'h00);
        check("lw_b", oprand_b, 32'd8);
        check("lw_mem_rd", 32'(mem_rd), 32'd1);
        check("lw_we", 32'(rd_we), 32'd1);
        drive(32'hFE612E23, 32'd100, 32'hDEAD_BEEF); step();
        check("sw_b", oprand_b, 32'hFFFF_FFFC);
        check("sw_mem_wr", 32'(mem_wr), 32'd1);
        check("sw_we", 32'(rd_we), 32'd0);
        check("sw_store_data", store_data, 32'hDEAD_BEEF);
        drive(32'h0000006F, 32'd1, 32'd1); step();
        check("jal_illegal", 32'(illegal), 32'd1);
        check("jal_alu", 32'(alu_code), 32'h3F);
        check("jal_we", 32'(rd_we), 32'd0);
        drive(32'h00000033, 32'd1, 32'd1); step();
        check("x0_illegal", 32'(illegal), 32'd0);
        check("x0_we", 32'(rd_we), 32'd0);
        in_valid = 1'b0; step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_alu", 32'(alu_code), 32'h3F);
        check("drain_count", issue_count, 32'd9);

        // Backpressure: slot holds add while execute stalls.
        drive(32'h002081B3, 32'd5, 32'd7); step();
        out_ready = 1'b0;
        drive(32'h402081B3, 32'd11, 32'd12);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_alu", 32'(alu_code), 32'h01);
            check("bp_a", oprand_a, 32'd5);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_count", issue_count, 32'd9);
        end
        out_ready = 1'b1; #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_next_alu", 32'(alu_code), 32'h0A);
        check("bp_next_a", oprand_a, 32'd11);
        check("bp_next_count", issue_count, 32'd10);
        step();
        check("bp_next2_count", issue_count, 32'd11);

        flush = 1'b1; drive(32'h123450B7, 32'd0, 32'd0); step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_alu", 32'(alu_code), 32'h3F);
        check("flush_count", issue_count, 32'd12);
        flush = 1'b0; in_valid = 1'b0; step();
        check("flush_dropped", 32'(out_valid), 32'd0);
        check("flush_count2", issue_count, 32'd12);

        drive(32'h002081B3, 32'd5, 32'd7); step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; flush = 1'b1; step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_alu", 32'(alu_code), 32'h3F);
        check("mid_rst_count", issue_count, 32'd0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

        // Randomized traffic against the queue model.
        exp_cnt = 0;
        q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit   rdy;
            exp_t e;
            rst       = ($urandom_range(199, 0) == 0);
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            flush     = ($urandom_range(15, 0) == 0);
            instr     = rand_instr();
            pc        = $urandom & 32'hFFFF_FFFC;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            #1;
            rdy = (q.size() == 0) || out_ready;
            check("r_in_ready", 32'(in_ready), 32'(rdy));
            if (rst) begin
                q.delete();
                exp_cnt = 0;
            end else begin
                if (q.size() != 0 && out_ready) begin
                    void'(q.pop_front());
                    exp_cnt++;
                end
                if (flush) q.delete();
                else if (in_valid && rdy) q.push_back(model(instr, pc, rs1_data, rs2_data));
            end
            step();
            check("r_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("r_issue_count", issue_count, exp_cnt);
            if (q.size() != 0) begin
                e = q[0];
                check("r_alu", 32'(alu_code), 32'(e.alu));
                check("r_a", oprand_a, e.a);
                check("r_b", oprand_b, e.b);
                check("r_store_data", store_data, e.sd);
                check("r_rd_addr", 32'(rd_addr), 32'(e.rd));
                check("r_ctrl", 32'({rd_we, mem_rd, mem_wr, illegal}),
                      32'({e.we, e.mr, e.mw, e.ill}));
            end else begin
                check("r_idle_alu", 32'(alu_code), 32'h3F);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
